// File: rtl/branch_comparator_pkg.sv
// Shared definitions for the branch comparator: operand width and the packed flag bundle.
package defines;

    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic ltu;
        logic lt;
        logic eq;
    } br_flags_t;

endpackage

// File: rtl/br_sat_counter.sv
// Saturating event counter: counts up on inc, holds at all-ones, clr beats inc.
module br_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_comparator.sv
// Branch condition comparator: combinational BrEq/BrLT/BrLTU plus a registered flag copy.
// Optional statistics counters are compiled in with `define BRANCH_CMP_STATS_EN.
module branch_comparator
    import defines::*;
#(
    parameter int DATA_WIDTH = defines::DATA_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rd_data1_i,
    input  logic [DATA_WIDTH-1:0] rd_data2_i,
    input  logic                  cmp_valid_i,
    output logic                  BrEq,
    output logic                  BrLT,
    output logic                  BrLTU,
    output logic [2:0]            flags_q_o,
`ifdef BRANCH_CMP_STATS_EN
    input  logic                  stats_clr_i,
    output logic [CNT_WIDTH-1:0]  eq_cnt_o,
    output logic [CNT_WIDTH-1:0]  lt_cnt_o,
    output logic [CNT_WIDTH-1:0]  ltu_cnt_o,
`endif
    output logic                  flags_valid_o
);

    logic signed [DATA_WIDTH-1:0] op1_s;
    logic signed [DATA_WIDTH-1:0] op2_s;
    br_flags_t                    flags_p0;
    br_flags_t                    flags_p1;
    logic                         vld_p1;

    assign op1_s = rd_data1_i;
    assign op2_s = rd_data2_i;

    // Stage p0: combinational compare, independent of clock, reset and valid
    always_comb begin
        flags_p0     = '0;
        flags_p0.eq  = (rd_data1_i == rd_data2_i);
        flags_p0.lt  = (op1_s < op2_s);
        flags_p0.ltu = (rd_data1_i < rd_data2_i);
    end

    assign BrEq  = flags_p0.eq;
    assign BrLT  = flags_p0.lt;
    assign BrLTU = flags_p0.ltu;

    // Stage p1: capture flags for the branch in decode, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= cmp_valid_i;
            if (cmp_valid_i) begin
                flags_p1 <= flags_p0;
            end
        end
    end

    assign flags_q_o     = flags_p1;
    assign flags_valid_o = vld_p1;

`ifdef BRANCH_CMP_STATS_EN
    br_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cmp_valid_i & flags_p0.eq),
        .clr   (stats_clr_i),
        .count (eq_cnt_o)
    );

    br_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cmp_valid_i & flags_p0.lt),
        .clr   (stats_clr_i),
        .count (lt_cnt_o)
    );

    br_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ltu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cmp_valid_i & flags_p0.ltu),
        .clr   (stats_clr_i),
        .count (ltu_cnt_o)
    );
`else
    // No statistics hardware; CNT_WIDTH is still sanity-checked so builds agree.
    if (CNT_WIDTH < 1) begin : g_cnt_width_chk
        $error("CNT_WIDTH must be at least 1");
    end
`endif

endmodule

// File: tb/tb_branch_comparator.sv
// Directed bench for branch_comparator; stats checks are active when BRANCH_CMP_STATS_EN is defined.
module tb_branch_comparator;

    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          cmp_valid;
    logic          br_eq;
    logic          br_lt;
    logic          br_ltu;
    logic [2:0]    flags_q;
    logic          flags_valid;
`ifdef BRANCH_CMP_STATS_EN
    logic          stats_clr;
    logic [CW-1:0] eq_cnt;
    logic [CW-1:0] lt_cnt;
    logic [CW-1:0] ltu_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_comparator #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_data1_i    (rd_data1),
        .rd_data2_i    (rd_data2),
        .cmp_valid_i   (cmp_valid),
        .BrEq          (br_eq),
        .BrLT          (br_lt),
        .BrLTU         (br_ltu),
        .flags_q_o     (flags_q),
`ifdef BRANCH_CMP_STATS_EN
        .stats_clr_i   (stats_clr),
        .eq_cnt_o      (eq_cnt),
        .lt_cnt_o      (lt_cnt),
        .ltu_cnt_o     (ltu_cnt),
`endif
        .flags_valid_o (flags_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand pairs with hand-computed {BrLTU, BrLT, BrEq}
    logic [DW-1:0] va [11] = '{32'd10, 32'd0, 32'hFFFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFE,
                               32'd10, 32'hFFFFFFFF, 32'h1, 32'h7FFFFFFF, 32'h80000000};
    logic [DW-1:0] vb [11] = '{32'd10, 32'd0, 32'hFFFFFFFF, 32'd10, 32'd1, 32'hFFFFFFFF,
                               32'd5, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [2:0]    ve [11] = '{3'b001, 3'b001, 3'b001, 3'b110, 3'b110, 3'b110,
                               3'b000, 3'b010, 3'b100, 3'b100, 3'b010};

    initial begin
        rd_data1  = '0;
        rd_data2  = '0;
        cmp_valid = 1'b0;
`ifdef BRANCH_CMP_STATS_EN
        stats_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("rst_flags_q", 64'(flags_q), 64'd0);
        chk("rst_flags_valid", 64'(flags_valid), 64'd0);
`ifdef BRANCH_CMP_STATS_EN
        chk("rst_eq_cnt", 64'(eq_cnt), 64'd0);
`endif

        // Combinational flags, exercised while reset is held
        for (int i = 0; i < 11; i++) begin
            rd_data1 = va[i];
            rd_data2 = vb[i];
            #1;
            chk($sformatf("comb_%0h_vs_%0h", va[i], vb[i]), 64'({br_ltu, br_lt, br_eq}), 64'(ve[i]));
        end

        tick();
        rst_n = 1'b1;
        tick();

        // Single valid pulse, then operands change with valid low
        rd_data1 = 32'd5; rd_data2 = 32'd10; cmp_valid = 1'b1;
        tick();
        chk("cap_flags_q", 64'(flags_q), 64'b110);
        chk("cap_flags_valid", 64'(flags_valid), 64'd1);
        cmp_valid = 1'b0; rd_data1 = 32'd10; rd_data2 = 32'd5;
        tick();
        chk("hold_flags_q", 64'(flags_q), 64'b110);
        chk("hold_flags_valid", 64'(flags_valid), 64'd0);
        chk("hold_comb", 64'({br_ltu, br_lt, br_eq}), 64'b000);
        rd_data1 = 32'd0; rd_data2 = 32'd1;
        tick();
        chk("hold2_flags_q", 64'(flags_q), 64'b110);

`ifdef BRANCH_CMP_STATS_EN
        rd_data1 = 32'd10; rd_data2 = 32'd10; cmp_valid = 1'b1;
        repeat (3) tick();
        cmp_valid = 1'b0;
        chk("stats_eq3", 64'(eq_cnt), 64'd3);
        chk("stats_lt1", 64'(lt_cnt), 64'd1);
        chk("stats_ltu1", 64'(ltu_cnt), 64'd1);
        chk("eq_flags_q", 64'(flags_q), 64'b001);
        cmp_valid = 1'b1; stats_clr = 1'b1;
        tick();
        cmp_valid = 1'b0; stats_clr = 1'b0;
        chk("clr_eq", 64'(eq_cnt), 64'd0);
        chk("clr_lt", 64'(lt_cnt), 64'd0);
        chk("clr_ltu", 64'(ltu_cnt), 64'd0);
        cmp_valid = 1'b1;
        repeat (9) tick();
        cmp_valid = 1'b0;
        chk("sat_eq", 64'(eq_cnt), 64'd7);
        chk("sat_lt", 64'(lt_cnt), 64'd0);
`endif

        // Reset dropped mid-run with a capture pending
        rd_data1 = 32'h1; rd_data2 = 32'hFFFFFFFF; cmp_valid = 1'b1;
        tick();
        chk("pre_rst_flags_q", 64'(flags_q), 64'b100);
        chk("pre_rst_flags_valid", 64'(flags_valid), 64'd1);
        rd_data1 = 32'd3; rd_data2 = 32'd3;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flags_q", 64'(flags_q), 64'd0);
        chk("mid_rst_flags_valid", 64'(flags_valid), 64'd0);
        chk("mid_rst_comb_eq", 64'({br_ltu, br_lt, br_eq}), 64'b001);
`ifdef BRANCH_CMP_STATS_EN
        chk("mid_rst_eq_cnt", 64'(eq_cnt), 64'd0);
        chk("mid_rst_ltu_cnt", 64'(ltu_cnt), 64'd0);
`endif
        rd_data1 = 32'h80000000; rd_data2 = 32'h7FFFFFFF;
        #1;
        chk("mid_rst_comb_lt", 64'({br_ltu, br_lt, br_eq}), 64'b010);
        cmp_valid = 1'b0;
        tick();
        chk("in_rst_flags_q", 64'(flags_q), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_flags_q", 64'(flags_q), 64'd0);
        chk("post_rst_flags_valid", 64'(flags_valid), 64'd0);
        rd_data1 = 32'hFFFFFFFF; rd_data2 = 32'h1; cmp_valid = 1'b1;
        tick();
        chk("post_rst_cap_q", 64'(flags_q), 64'b010);
        chk("post_rst_cap_valid", 64'(flags_valid), 64'd1);
        cmp_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
